dcache_wr_buffer: RTL and testbench

DCACHE_WR_BUFFER -- requirements
Module: dcache_wr_buffer

---
 rtl/dcache_wr_buffer_pkg.sv | 21 ++
 rtl/dcache_wr_buffer_wb_fifo.sv | 68 ++++++
 rtl/dcache_wr_buffer.sv | 102 ++++++++++
 tb/tb_dcache_wr_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_wr_buffer_pkg.sv
// Shared CPU header: write-type encodings, line geometry and the
// per-entry metadata record used by the write buffer and its FIFO.
package dcache_wr_buffer_pkg;

  localparam logic [2:0] WR_LINE     = 3'b100;
  localparam logic [2:0] WR_WORD     = 3'b010;
  localparam int         LINE_OFF_W  = 4;
  localparam int         LINE_ADDR_W = 32 - LINE_OFF_W;

  typedef struct packed {
    logic [2:0]  wr_type;
    logic [31:0] addr;
    logic [3:0]  wstrb;
  } wb_meta_t;

  // Line number of a byte address (drops the offset within the line).
  function automatic logic [LINE_ADDR_W-1:0] line_of(input logic [31:0] addr);
    return addr[31:LINE_OFF_W];
  endfunction

endpackage

// File: rtl/dcache_wr_buffer_wb_fifo.sv
// Write-buffer storage: DEPTH-entry FIFO with wrap-bit pointers. Exposes the
// head entry plus a per-slot occupancy mask and line address for hazard checks.
module wb_fifo
  import dcache_wr_buffer_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int LINE_W = 128
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic                                  i_push,
  input  logic                                  i_pop,
  input  wb_meta_t                              i_meta,
  input  logic [LINE_W-1:0]                     i_data,
  output logic                                  o_full,
  output logic                                  o_empty,
  output wb_meta_t                              o_head_meta,
  output logic [LINE_W-1:0]                     o_head_data,
  output logic [DEPTH-1:0]                      o_vld,
  output logic [DEPTH-1:0][LINE_ADDR_W-1:0]     o_line_addr
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  wb_meta_t          r_meta [DEPTH];
  logic [LINE_W-1:0] r_data [DEPTH];
  logic [AW:0]       w_count;

  assign w_count     = r_wptr - r_rptr;
  assign o_empty     = (r_wptr == r_rptr);
  assign o_full      = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign o_head_meta = r_meta[r_rptr[AW-1:0]];
  assign o_head_data = r_data[r_rptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty across wrap.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Entry storage is written on push only and never cleared.
  always_ff @(posedge aclk) begin
    if (i_push) begin
      r_meta[r_wptr[AW-1:0]] <= i_meta;
      r_data[r_wptr[AW-1:0]] <= i_data;
    end
  end

  // Slot i is occupied when its distance from the read index is below the count.
  always_comb begin
    o_vld       = '0;
    o_line_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] w_off;
      w_off          = AW'(i) - r_rptr[AW-1:0];
      o_vld[i]       = ({1'b0, w_off} < w_count);
      o_line_addr[i] = line_of(r_meta[i].addr);
    end
  end

endmodule

// File: rtl/dcache_wr_buffer.sv
// Dcache write buffer: queues dirty-line victims and uncached stores, issues
// them one at a time to the AXI bridge write port, and flags read misses that
// hit a queued or in-flight write line.
module dcache_wr_buffer
  import dcache_wr_buffer_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int LINE_W = 128
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_type,
  input  logic [31:0]       in_addr,
  input  logic [3:0]        in_wstrb,
  input  logic [LINE_W-1:0] in_data,
  output logic              wr_req,
  output logic [2:0]        wr_type,
  output logic [31:0]       wr_addr,
  output logic [3:0]        wr_wstrb,
  output logic [LINE_W-1:0] wr_data,
  input  logic              wr_rdy,
  input  logic [31:0]       chk_addr,
  output logic              chk_hit,
  output logic              drained
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]                          r_state;
  logic [LINE_ADDR_W-1:0]              r_infl_addr;
  logic                                w_full;
  logic                                w_empty;
  logic                                w_push;
  logic                                w_pop;
  logic                                w_idle;
  logic                                w_buf_hit;
  wb_meta_t                            w_in_meta;
  wb_meta_t                            w_head_meta;
  logic [DEPTH-1:0]                    w_vld;
  logic [DEPTH-1:0][LINE_ADDR_W-1:0]   w_line_addr;

  assign w_idle    = (r_state == S_IDLE);
  assign in_ready  = ~w_full;
  assign w_push    = in_valid & ~w_full;
  assign wr_req    = w_idle & ~w_empty;
  assign w_pop     = wr_req & wr_rdy;
  assign drained   = w_empty & w_idle;
  assign w_in_meta = '{wr_type: in_type, addr: in_addr, wstrb: in_wstrb};
  assign wr_type   = w_head_meta.wr_type;
  assign wr_addr   = w_head_meta.addr;
  assign wr_wstrb  = w_head_meta.wstrb;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W)
  ) u_fifo (
    .aclk        (aclk),
    .areset      (areset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_meta      (w_in_meta),
    .i_data      (in_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_meta (w_head_meta),
    .o_head_data (wr_data),
    .o_vld       (w_vld),
    .o_line_addr (w_line_addr)
  );

  // Issue FSM: one write in flight; the bridge reports completion via wr_rdy.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_pop)  r_state <= S_BUSY;
        S_BUSY:  if (wr_rdy) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line of the accepted write; only meaningful while BUSY.
  always_ff @(posedge aclk) begin
    if (w_pop) r_infl_addr <= line_of(wr_addr);
  end

  // Read-after-write hazard: any queued entry or the in-flight write on the same line.
  always_comb begin
    w_buf_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_vld[i] && (w_line_addr[i] == line_of(chk_addr))) w_buf_hit = 1'b1;
    end
  end

  assign chk_hit = w_buf_hit | ((r_state == S_BUSY) && (r_infl_addr == line_of(chk_addr)));

endmodule

// File: tb/tb_dcache_wr_buffer.sv
// Directed testbench for dcache_wr_buffer (DEPTH=2, LINE_W=128).
module tb_dcache_wr_buffer;

  localparam int LINE_W = 128;

  logic              aclk;
  logic              areset;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_type;
  logic [31:0]       in_addr;
  logic [3:0]        in_wstrb;
  logic [LINE_W-1:0] in_data;
  logic              wr_req;
  logic [2:0]        wr_type;
  logic [31:0]       wr_addr;
  logic [3:0]        wr_wstrb;
  logic [LINE_W-1:0] wr_data;
  logic              wr_rdy;
  logic [31:0]       chk_addr;
  logic              chk_hit;
  logic              drained;

  int n_cmp = 0;
  int n_err = 0;

  dcache_wr_buffer #(.DEPTH(2), .LINE_W(LINE_W)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_type  (in_type),
    .in_addr  (in_addr),
    .in_wstrb (in_wstrb),
    .in_data  (in_data),
    .wr_req   (wr_req),
    .wr_type  (wr_type),
    .wr_addr  (wr_addr),
    .wr_wstrb (wr_wstrb),
    .wr_data  (wr_data),
    .wr_rdy   (wr_rdy),
    .chk_addr (chk_addr),
    .chk_hit  (chk_hit),
    .drained  (drained)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    areset   = 1'b1;
    in_valid = 1'b0;
    in_type  = 3'b100;
    in_addr  = '0;
    in_wstrb = 4'hF;
    in_data  = '0;
    wr_rdy   = 1'b0;
    chk_addr = 32'h0;

    // Reset state during and directly after reset
    step(); step();
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_req",   wr_req,   0);
    chk("rst_chk_hit",  chk_hit,  0);
    chk("rst_drained",  drained,  1);
    areset = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_drained",  drained,  1);

    // Line write, 1-cycle latency, long BUSY
    wr_rdy   = 1'b1;
    in_valid = 1'b1;
    in_type  = 3'b100;
    in_addr  = 32'h1C00_0040;
    in_wstrb = 4'hF;
    in_data  = 128'h44444444_33333333_22222222_11111111;
    #1;
    chk("line_req_same_cycle", wr_req, 0);
    step();
    in_valid = 1'b0;
    #1;
    chk("line_req",   wr_req,   1);
    chk("line_type",  wr_type,  3'b100);
    chk("line_addr",  wr_addr,  32'h1C00_0040);
    chk("line_wstrb", wr_wstrb, 4'hF);
    chk("line_data",  wr_data,  128'h44444444_33333333_22222222_11111111);
    step();
    wr_rdy = 1'b0;
    #1;
    chk("line_busy_req",     wr_req,  0);
    chk("line_busy_drained", drained, 0);
    for (int i = 0; i < 5; i++) step();
    chk("line_wait_drained", drained, 0);
    wr_rdy = 1'b1;
    step();
    chk("line_done_drained", drained, 1);

    // Fill with wr_rdy low, refuse third push, issue in order
    wr_rdy   = 1'b0;
    in_valid = 1'b1;
    in_addr  = 32'h0000_0100;
    in_data  = {4{32'hAAAA_0001}};
    step();
    in_addr  = 32'h0000_0200;
    in_data  = {4{32'hBBBB_0002}};
    step();
    in_addr  = 32'h0000_0300;
    in_data  = {4{32'hCCCC_0003}};
    #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_head_A",   wr_addr,  32'h0000_0100);
    step();
    in_valid = 1'b0;
    wr_rdy   = 1'b1;
    #1;
    chk("order_first_addr", wr_addr, 32'h0000_0100);
    chk("order_first_data", wr_data, {4{32'hAAAA_0001}});
    step();
    chk("order_busy_req", wr_req, 0);
    step();
    chk("order_second_req",  wr_req,   1);
    chk("order_second_addr", wr_addr,  32'h0000_0200);
    chk("order_second_data", wr_data,  {4{32'hBBBB_0002}});
    chk("order_in_ready",    in_ready, 1);
    step(); step();
    chk("order_third_refused", drained, 1);

    // Hazard check against a queued entry, then in-flight, then cleared
    wr_rdy   = 1'b0;
    in_valid = 1'b1;
    in_type  = 3'b010;
    in_addr  = 32'h0000_1230;
    in_wstrb = 4'b1111;
    in_data  = 128'h0000_5678;
    chk_addr = 32'h0000_1230;
    #1;
    chk("hit_same_cycle_push", chk_hit, 0);
    step();
    in_valid = 1'b0;
    chk_addr = 32'h0000_123C;
    #1;
    chk("hit_queued", chk_hit, 1);
    chk_addr = 32'h0000_1240;
    #1;
    chk("hit_other_line", chk_hit, 0);
    chk_addr = 32'h0000_123C;
    wr_rdy   = 1'b1;
    step();
    wr_rdy = 1'b0;
    #1;
    chk("hit_inflight", chk_hit, 1);
    step();
    chk("hit_inflight_hold", chk_hit, 1);
    wr_rdy = 1'b1;
    step();
    chk("hit_cleared", chk_hit, 0);
    chk("hit_drained", drained, 1);

    // Word write forwarding
    wr_rdy   = 1'b0;
    in_valid = 1'b1;
    in_type  = 3'b010;
    in_addr  = 32'hBFAF_0000;
    in_wstrb = 4'b0011;
    in_data  = 128'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    #1;
    chk("word_type",  wr_type,  3'b010);
    chk("word_wstrb", wr_wstrb, 4'b0011);
    chk("word_addr",  wr_addr,  32'hBFAF_0000);
    chk("word_data",  wr_data,  128'hDEAD_BEEF);
    wr_rdy = 1'b1;
    step(); step();
    chk("word_drained", drained, 1);

    // Simultaneous push/pop with one entry resident, across pointer wrap
    wr_rdy   = 1'b0;
    in_valid = 1'b1;
    in_type  = 3'b100;
    in_wstrb = 4'hF;
    in_addr  = 32'h2000_0000;
    in_data  = {4{32'h0}};
    step();
    for (int k = 1; k <= 9; k++) begin
      in_valid = 1'b1;
      in_addr  = 32'h2000_0000 + 32'(k * 16);
      in_data  = {4{32'(k)}};
      wr_rdy   = 1'b1;
      #1;
      chk("pp_head_addr", wr_addr, 32'h2000_0000 + 32'((k - 1) * 16));
      chk("pp_head_data", wr_data, {4{32'(k - 1)}});
      step();
      in_valid = 1'b0;
      step();
      chk("pp_occupied", wr_req, 1);
    end
    chk("pp_last_addr", wr_addr, 32'h2000_0090);
    chk("pp_last_data", wr_data, {4{32'd9}});
    step(); step();
    chk("pp_drained", drained, 1);

    // Reset while BUSY with one entry queued
    wr_rdy   = 1'b0;
    in_valid = 1'b1;
    in_addr  = 32'h3000_0000;
    step();
    in_addr  = 32'h3000_0010;
    wr_rdy   = 1'b1;
    step();
    in_valid = 1'b0;
    wr_rdy   = 1'b0;
    chk_addr = 32'h3000_0010;
    #1;
    chk("mid_busy_drained", drained, 0);
    chk("mid_busy_hit",     chk_hit, 1);
    areset = 1'b1;
    step();
    areset = 1'b0;
    #1;
    chk("mid_rst_wr_req",   wr_req,   0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_drained",  drained,  1);
    chk("mid_rst_chk_hit",  chk_hit,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
